sci_master_ctrl: RTL and testbench

SCI_MASTER_CTRL -- requirements
Module: sci_master_ctrl

---
 rtl/sci_pkg.sv | 29 ++
 rtl/sci_shift_reg.sv | 38 +++
 rtl/sci_master_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_sci_master_ctrl.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sci_pkg.sv
// Shared definitions for the SCI master: controller state encoding and
// bit-counter sizing helpers.
// No ports; imported by sci_master_ctrl.
package sci_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_START    = 3'd1,
    ST_ADDR     = 3'd2,
    ST_WDATA    = 3'd3,
    ST_WAIT_ACK = 3'd4,
    ST_RDATA    = 3'd5,
    ST_RESP     = 3'd6
  } sci_state_e;

  function automatic int sci_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Width of the bit counter shared by ADDR, WDATA and RDATA (never below 1).
  function automatic int sci_cnt_w(input int aw, input int dw);
    return sci_max(sci_max($clog2(aw), $clog2(dw)), 1);
  endfunction

  localparam int SCI_ADDR_W_DEF = 8;
  localparam int SCI_DATA_W_DEF = 8;
  localparam int SCI_BIT_CNT_W  = sci_max($clog2(SCI_ADDR_W_DEF), $clog2(SCI_DATA_W_DEF));

endpackage

// File: rtl/sci_shift_reg.sv
// Parallel-load, MSB-first shift register used both to serialise address/write
// data and to capture read data (serial input enters at the LSB).
// Ports: clk_i, rst_i (sync, active high), load_i/load_dat_i, shift_i/ser_i, q_o.
module sci_shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_dat_i,
  input  logic             shift_i,
  input  logic             ser_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] sh_q, sh_d;

  // Load wins over shift so the last address cycle can preload write data.
  always_comb begin
    sh_d = sh_q;
    if (load_i) begin
      sh_d = load_dat_i;
    end else if (shift_i) begin
      sh_d = {sh_q[WIDTH-2:0], ser_i};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sh_q <= '0;
    end else begin
      sh_q <= sh_d;
    end
  end

  assign q_o = sh_q;

endmodule

// File: rtl/sci_master_ctrl.sv
// SCI serial master: accepts one command, drives chip select plus a serial
// request (WNR, address, write data), waits for ACK with timeout, captures
// read data, and reports one RSP_VALID pulse.
// Ports: CLK/RST (sync, active high), CMD_* command handshake, RSP_* response,
// SCI_CSN/SCI_REQ to slaves, SCI_RESP/SCI_ACK from slaves.
// ADDR_WIDTH and DATA_WIDTH must both be at least 2.
module sci_master_ctrl
  import sci_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int NUM_SLAVES = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  CMD_VALID,
  output logic                  CMD_READY,
  input  logic                  CMD_WNR,
  input  logic [((NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1)-1:0] CMD_SEL,
  input  logic [ADDR_WIDTH-1:0] CMD_ADDR,
  input  logic [DATA_WIDTH-1:0] CMD_WDATA,
  output logic                  RSP_VALID,
  output logic [DATA_WIDTH-1:0] RSP_RDATA,
  output logic                  RSP_ERR,
  output logic [NUM_SLAVES-1:0] SCI_CSN,
  output logic                  SCI_REQ,
  input  logic                  SCI_RESP,
  input  logic                  SCI_ACK
);

  localparam int SEL_W  = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int CNT_W  = sci_cnt_w(ADDR_WIDTH, DATA_WIDTH);
  localparam int TCNT_W = sci_max($clog2(TIMEOUT), 1);
  localparam int SW     = sci_max(ADDR_WIDTH, DATA_WIDTH);

  sci_state_e            state_q, state_d;
  logic                  wnr_q;
  logic [SEL_W-1:0]      sel_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [TCNT_W-1:0]     tcnt_q, tcnt_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;
  logic                  cmd_take;
  logic                  sh_load, sh_shift, sh_ser;
  logic [SW-1:0]         sh_load_dat, sh_q;
  logic                  sel_ok;
  logic                  csn_on;

  assign sel_ok = (32'(sel_q) < NUM_SLAVES);

  sci_shift_reg #(.WIDTH(SW)) u_shift (
    .clk_i      (CLK),
    .rst_i      (RST),
    .load_i     (sh_load),
    .load_dat_i (sh_load_dat),
    .shift_i    (sh_shift),
    .ser_i      (sh_ser),
    .q_o        (sh_q)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    tcnt_d      = tcnt_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    cmd_take    = 1'b0;
    sh_load     = 1'b0;
    sh_load_dat = '0;
    sh_shift    = 1'b0;
    sh_ser      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (CMD_VALID) begin
          cmd_take = 1'b1;
          sh_load  = 1'b1;
          sh_load_dat[SW-1 -: ADDR_WIDTH] = CMD_ADDR;
          state_d  = ST_START;
        end
      end
      ST_START: begin
        cnt_d = '0;
        if (sel_ok) begin
          state_d = ST_ADDR;
        end else begin
          // Unknown slave: answer with an error without touching the bus.
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
          state_d     = ST_RESP;
        end
      end
      ST_ADDR: begin
        sh_shift = 1'b1;
        if (cnt_q == CNT_W'(ADDR_WIDTH - 1)) begin
          cnt_d = '0;
          if (wnr_q) begin
            sh_load = 1'b1;
            sh_load_dat[SW-1 -: DATA_WIDTH] = wdata_q;
            state_d = ST_WDATA;
          end else begin
            tcnt_d  = '0;
            state_d = ST_WAIT_ACK;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_WDATA: begin
        sh_shift = 1'b1;
        if (cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
          cnt_d   = '0;
          tcnt_d  = '0;
          state_d = ST_WAIT_ACK;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_WAIT_ACK: begin
        tcnt_d = tcnt_q + TCNT_W'(1);
        if (SCI_ACK) begin
          if (wnr_q) begin
            rsp_err_d   = 1'b0;
            rsp_rdata_d = '0;
            state_d     = ST_RESP;
          end else begin
            // The ACK cycle already carries the read-data MSB.
            sh_shift = 1'b1;
            sh_ser   = SCI_RESP;
            cnt_d    = '0;
            state_d  = ST_RDATA;
          end
        end else if (tcnt_q == TCNT_W'(TIMEOUT - 1)) begin
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
          state_d     = ST_RESP;
        end
      end
      ST_RDATA: begin
        sh_shift = 1'b1;
        sh_ser   = SCI_RESP;
        if (cnt_q == CNT_W'(DATA_WIDTH - 2)) begin
          rsp_rdata_d = {sh_q[DATA_WIDTH-2:0], SCI_RESP};
          rsp_err_d   = 1'b0;
          state_d     = ST_RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      wnr_q       <= 1'b0;
      sel_q       <= '0;
      wdata_q     <= '0;
      cnt_q       <= '0;
      tcnt_q      <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tcnt_q      <= tcnt_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      if (cmd_take) begin
        wnr_q   <= CMD_WNR;
        sel_q   <= CMD_SEL;
        wdata_q <= CMD_WDATA;
      end
    end
  end

  // Chip select is held from START through the last serial cycle; outputs are
  // forced idle while RST is high so an abort is visible immediately.
  assign csn_on = !RST && sel_ok &&
                  (state_q == ST_START || state_q == ST_ADDR || state_q == ST_WDATA ||
                   state_q == ST_WAIT_ACK || state_q == ST_RDATA);

  always_comb begin
    SCI_CSN = '1;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (csn_on && (32'(sel_q) == i)) SCI_CSN[i] = 1'b0;
    end
  end

  always_comb begin
    SCI_REQ = 1'b0;
    if (!RST) begin
      case (state_q)
        ST_START:          SCI_REQ = wnr_q;
        ST_ADDR, ST_WDATA: SCI_REQ = sh_q[SW-1];
        default:           SCI_REQ = 1'b0;
      endcase
    end
  end

  assign CMD_READY = !RST && (state_q == ST_IDLE);
  assign RSP_VALID = !RST && (state_q == ST_RESP);
  assign RSP_RDATA = rsp_rdata_q;
  assign RSP_ERR   = rsp_err_q;

endmodule

// File: tb/tb_sci_master_ctrl.sv
module tb_sci_master_ctrl;

  logic       CLK = 1'b0;
  logic       RST;
  always #5 CLK = ~CLK;

  logic       cmd_valid, cmd_ready, cmd_wnr;
  logic [1:0] cmd_sel;
  logic [7:0] cmd_addr, cmd_wdata, rsp_rdata;
  logic       rsp_valid, rsp_err, sci_req, sci_resp, sci_ack;
  logic [3:0] sci_csn;

  logic       d2_valid, d2_ready, d2_valid_o, d2_err, d2_req;
  logic [2:0] d2_sel;
  logic [7:0] d2_rdata;
  logic [4:0] d2_csn;
  logic       d2_zero = 1'b0;

  sci_master_ctrl dut (
    .CLK(CLK), .RST(RST), .CMD_VALID(cmd_valid), .CMD_READY(cmd_ready),
    .CMD_WNR(cmd_wnr), .CMD_SEL(cmd_sel), .CMD_ADDR(cmd_addr), .CMD_WDATA(cmd_wdata),
    .RSP_VALID(rsp_valid), .RSP_RDATA(rsp_rdata), .RSP_ERR(rsp_err),
    .SCI_CSN(sci_csn), .SCI_REQ(sci_req), .SCI_RESP(sci_resp), .SCI_ACK(sci_ack)
  );

  // Five slaves give a 3-bit select, so index 5 is representable but invalid.
  sci_master_ctrl #(.NUM_SLAVES(5)) dut2 (
    .CLK(CLK), .RST(RST), .CMD_VALID(d2_valid), .CMD_READY(d2_ready),
    .CMD_WNR(d2_zero), .CMD_SEL(d2_sel), .CMD_ADDR(8'h00), .CMD_WDATA(8'h00),
    .RSP_VALID(d2_valid_o), .RSP_RDATA(d2_rdata), .RSP_ERR(d2_err),
    .SCI_CSN(d2_csn), .SCI_REQ(d2_req), .SCI_RESP(d2_zero), .SCI_ACK(d2_zero)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        err;
    logic [7:0]  rdata;
    logic [3:0]  csn;
    logic [16:0] stream;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   rsp_cycs[$];
  int   start_cycs[$];

  function automatic exp_t mk(input logic err, input logic [7:0] rdata, input logic [3:0] csn,
                              input logic [16:0] stream, input int lat);
    exp_t e;
    e.err = err; e.rdata = rdata; e.csn = csn; e.stream = stream; e.lat = lat;
    return e;
  endfunction

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // Slave model configuration and observations.
  logic        cfg_ack_en = 1'b0;
  int          cfg_ack_dly = 0;
  logic [7:0]  cfg_rdata = 8'h00;
  logic        cfg_noise = 1'b0;
  logic [3:0]  obs_csn = 4'hF;
  logic [16:0] obs_stream = '0;
  int          entry_cyc = 0;
  int          sn = 0;
  logic        s_wnr = 1'b0;
  logic        ready_bad = 1'b0;

  initial begin : slave
    int s_len, s_ack_n;
    forever begin
      @(negedge CLK);
      sci_ack  = 1'b0;
      sci_resp = 1'b0;
      if (sci_csn === 4'hF) begin
        sn = 0;
      end else begin
        if (sn == 0) begin
          s_wnr      = sci_req;
          obs_csn    = sci_csn;
          obs_stream = '0;
          start_cycs.push_back(cyc);
        end
        s_len   = s_wnr ? 17 : 9;
        s_ack_n = s_len + cfg_ack_dly;
        if (sn < s_len) obs_stream = {obs_stream[15:0], sci_req};
        if (sn == s_len) entry_cyc = cyc;
        if (cfg_noise && sn < s_len) begin
          sci_ack  = 1'b1;
          sci_resp = 1'b1;
        end else if (cfg_ack_en && sn == s_ack_n) begin
          sci_ack  = 1'b1;
          sci_resp = cfg_rdata[7];
        end else if (cfg_ack_en && !s_wnr && sn > s_ack_n && sn <= s_ack_n + 7) begin
          sci_resp = cfg_rdata[7 - (sn - s_ack_n)];
        end
        sn++;
      end
    end
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge CLK);
      if (cmd_ready === 1'b1 && (sci_csn !== 4'hF || rsp_valid === 1'b1)) ready_bad = 1'b1;
      if (rsp_valid === 1'b1) begin
        rsp_cycs.push_back(cyc);
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_rsp: got RSP_VALID expected none");
        end else begin
          e = sb.pop_front();
          chk("rsp_err", 32'(rsp_err), 32'(e.err));
          chk("rsp_rdata", 32'(rsp_rdata), 32'(e.rdata));
          chk("csn_in_resp", 32'(sci_csn), 32'hF);
          chk("ready_in_resp", 32'(cmd_ready), 32'h0);
          chk("csn_selected", 32'(obs_csn), 32'(e.csn));
          chk("req_stream", 32'(obs_stream), 32'(e.stream));
          chk("rsp_latency", 32'(cyc - entry_cyc), 32'(e.lat));
        end
      end
    end
  end

  task automatic send(input logic wnr, input logic [1:0] sel, input logic [7:0] addr,
                      input logic [7:0] wdata, input exp_t e, input bit push, input bit keep);
    bit acc;
    if (push) sb.push_back(e);
    @(negedge CLK);
    cmd_valid = 1'b1; cmd_wnr = wnr; cmd_sel = sel; cmd_addr = addr; cmd_wdata = wdata;
    acc = 1'b0;
    for (int k = 0; k < 300; k++) begin
      if (cmd_ready === 1'b1) begin
        @(posedge CLK);
        acc = 1'b1;
        break;
      end
      @(negedge CLK);
    end
    if (!acc) chk("accept_timeout", 32'h0, 32'h1);
    @(negedge CLK);
    if (!keep) cmd_valid = 1'b0;
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(negedge CLK);
      if (sb.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) chk("drain_timeout", 32'(sb.size()), 32'h0);
    repeat (3) @(negedge CLK);
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    bit got, d2_csn_bad;
    cmd_valid = 0; cmd_wnr = 0; cmd_sel = 0; cmd_addr = 0; cmd_wdata = 0;
    d2_valid = 0; d2_sel = 0;
    sci_ack = 0; sci_resp = 0;
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    chk("rst_ready", 32'(cmd_ready), 32'h0);
    chk("rst_csn", 32'(sci_csn), 32'hF);
    chk("rst_req", 32'(sci_req), 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_rdata", 32'(rsp_rdata), 32'h0);
    chk("rst_err", 32'(rsp_err), 32'h0);
    RST = 1'b0;
    #1 chk("ready_after_rst", 32'(cmd_ready), 32'h1);

    // Write sel1 A5/3C, ACK in the 6th WAIT_ACK cycle.
    cfg_ack_en = 1; cfg_ack_dly = 5; cfg_noise = 0;
    send(1'b1, 2'd1, 8'hA5, 8'h3C, mk(1'b0, 8'h00, 4'b1101, 17'h1A53C, 6), 1, 0);
    drain();

    // Read sel0 addr 0x12, data 0xC3; ACK/RESP noise during START/ADDR must be ignored.
    cfg_ack_dly = 2; cfg_rdata = 8'hC3; cfg_noise = 1;
    send(1'b0, 2'd0, 8'h12, 8'h00, mk(1'b0, 8'hC3, 4'b1110, 17'h00012, 10), 1, 0);
    drain();
    cfg_noise = 0;
    repeat (5) @(negedge CLK);
    chk("rdata_hold", 32'(rsp_rdata), 32'hC3);

    // Back-to-back writes with CMD_VALID held high.
    cfg_ack_dly = 1;
    rsp_cycs.delete();
    start_cycs.delete();
    send(1'b1, 2'd3, 8'h01, 8'h80, mk(1'b0, 8'h00, 4'b0111, 17'h10180, 2), 1, 1);
    send(1'b1, 2'd0, 8'hFF, 8'h00, mk(1'b0, 8'h00, 4'b1110, 17'h1FF00, 2), 1, 0);
    drain();
    if (rsp_cycs.size() >= 1 && start_cycs.size() >= 2)
      chk("b2b_gap", 32'(start_cycs[1] - rsp_cycs[0]), 32'd2);
    else
      chk("b2b_count", 32'(start_cycs.size()), 32'd2);

    // Read with no ACK: timeout 64 cycles after WAIT_ACK entry.
    cfg_ack_en = 0;
    send(1'b0, 2'd2, 8'h7E, 8'h00, mk(1'b1, 8'h00, 4'b1011, 17'h0007E, 64), 1, 0);
    drain();

    // Reset during ADDR bit 3 aborts without a response.
    cfg_ack_en = 1; cfg_ack_dly = 0; cfg_rdata = 8'hFF;
    send(1'b0, 2'd1, 8'h55, 8'h00, mk(1'b0, 8'h00, 4'h0, 17'h0, 0), 0, 0);
    repeat (3) @(negedge CLK);
    chk("csn_before_abort", 32'(sci_csn), 32'hD);
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    chk("csn_after_abort", 32'(sci_csn), 32'hF);
    chk("rsp_after_abort", 32'(rsp_valid), 32'h0);
    RST = 1'b0;
    #1 chk("ready_after_abort", 32'(cmd_ready), 32'h1);
    repeat (20) @(negedge CLK);
    cfg_ack_dly = 3; cfg_rdata = 8'h5A;
    send(1'b0, 2'd3, 8'h9A, 8'h00, mk(1'b0, 8'h5A, 4'b0111, 17'h0009A, 11), 1, 0);
    drain();

    // Out-of-range select on the five-slave instance.
    @(negedge CLK);
    d2_valid = 1'b1; d2_sel = 3'd5;
    got = 1'b0; d2_csn_bad = 1'b0;
    for (int k = 0; k < 30; k++) begin
      if (d2_csn !== 5'h1F) d2_csn_bad = 1'b1;
      if (d2_valid_o === 1'b1) begin
        got = 1'b1;
        chk("badsel_err", 32'(d2_err), 32'h1);
        chk("badsel_rdata", 32'(d2_rdata), 32'h0);
        break;
      end
      if (d2_ready === 1'b1 && d2_valid === 1'b1) begin
        @(posedge CLK);
        @(negedge CLK);
        d2_valid = 1'b0;
      end else begin
        @(negedge CLK);
      end
    end
    chk("badsel_rsp_seen", 32'(got), 32'h1);
    chk("badsel_csn_idle", 32'(d2_csn_bad), 32'h0);
    chk("ready_only_idle", 32'(ready_bad), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
